and2_latch_tester: RTL and testbench

//  Self-checking stimulus/response partner for the 2-input AND with clocked output micro benchmark.
//  - Drives operands a/b into the DUT.
//  - Checks the DUT's combinational output c and registered output d against a golden model.
//  - Counts mismatches and reports pass/fail.

---
 rtl/and2_latch_tester_if.sv | 11 +
 rtl/and2_latch_tester.sv | 145 ++++++++++++++
 tb/tb_and2_latch_tester.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/and2_latch_tester_if.sv
// Operand/response bus between the tester and the AND2 device under test.
// master = tester (drives a/b, samples c/d); slave = device under test.
interface and2_latch_tester_if;
   logic a;
   logic b;
   logic c;
   logic d;

   modport master (output a, output b, input c, input d);
   modport slave  (input a, input b, output c, output d);
endinterface

// File: rtl/and2_latch_tester.sv
// Stimulus/response tester for a 2-input AND with combinational (c) and registered (d) outputs.
// Optional build macro AND2_LATCH_TESTER_LFSR_EN: operands come from an 8-bit LFSR instead of a counter.
module and2_latch_tester #(
   parameter int NUM_VECTORS = 16,
   parameter int ERR_W       = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_start,
   and2_latch_tester_if.master  io_dut,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_pass,
   output logic [ERR_W-1:0]     o_err_cnt
);

   localparam int VCNT_W = $clog2(NUM_VECTORS + 1);
   localparam logic [VCNT_W-1:0] LAST_VEC = VCNT_W'(NUM_VECTORS - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t              r_state;
   logic [VCNT_W-1:0]   r_vcnt;
   logic                r_d_chk_vld;
   logic                r_exp_d;
   logic                r_a;
   logic                r_b;
   logic [ERR_W-1:0]    r_err_cnt;
   logic                r_busy;
   logic                r_done;
   logic                r_pass;

   logic [VCNT_W-1:0]   w_vcnt_inc;
   logic [1:0]          w_vec0;      // {a,b} for the first vector of a run
   logic [1:0]          w_vec_next;  // {a,b} for the vector after the current one
   logic                w_ab_and;
   logic                w_c_err;
   logic                w_d_err;
   logic [ERR_W:0]      w_err_sum;
   logic [ERR_W-1:0]    w_err_next;

   assign w_vcnt_inc = r_vcnt + VCNT_W'(1);

`ifdef AND2_LATCH_TESTER_LFSR_EN
   localparam logic [7:0] LFSR_SEED = 8'hA5;

   logic [7:0] r_lfsr;
   logic [7:0] w_lfsr_step;

   // Fibonacci form of x^8+x^6+x^5+x^4+1: feedback from bits 7,5,4,3 into bit 0.
   assign w_lfsr_step = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
   assign w_vec0      = {LFSR_SEED[0], LFSR_SEED[1]};
   assign w_vec_next  = {w_lfsr_step[0], w_lfsr_step[1]};
`else
   assign w_vec0 = 2'b00;
   generate
      if (VCNT_W >= 2) begin : g_vec_wide
         assign w_vec_next = w_vcnt_inc[1:0];
      end else begin : g_vec_narrow
         assign w_vec_next = {1'b0, w_vcnt_inc[0]};
      end
   endgenerate
`endif

   assign w_ab_and = r_a & r_b;
   assign w_c_err  = (r_state == S_RUN) && (io_dut.c != w_ab_and);
   assign w_d_err  = ((r_state == S_RUN) || (r_state == S_DRAIN)) && r_d_chk_vld &&
                     (io_dut.d != r_exp_d);

   // One spare bit catches overflow so the counter can clamp instead of wrapping.
   assign w_err_sum  = {1'b0, r_err_cnt} + (ERR_W+1)'(w_c_err) + (ERR_W+1)'(w_d_err);
   assign w_err_next = w_err_sum[ERR_W] ? {ERR_W{1'b1}} : w_err_sum[ERR_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_vcnt      <= '0;
         r_d_chk_vld <= 1'b0;
         r_exp_d     <= 1'b0;
         r_a         <= 1'b0;
         r_b         <= 1'b0;
         r_err_cnt   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
`ifdef AND2_LATCH_TESTER_LFSR_EN
         r_lfsr      <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  r_state      <= S_RUN;
                  r_vcnt       <= '0;
                  r_d_chk_vld  <= 1'b0;
                  r_err_cnt    <= '0;
                  {r_a, r_b}   <= w_vec0;
                  r_busy       <= 1'b1;
                  r_done       <= 1'b0;
                  r_pass       <= 1'b0;
`ifdef AND2_LATCH_TESTER_LFSR_EN
                  r_lfsr       <= LFSR_SEED;
`endif
               end
            end

            S_RUN: begin
               r_err_cnt   <= w_err_next;
               r_d_chk_vld <= 1'b1;
               r_exp_d     <= w_ab_and;
`ifdef AND2_LATCH_TESTER_LFSR_EN
               r_lfsr      <= w_lfsr_step;
`endif
               // The last vector stays on a/b through DRAIN so its registered product can be checked.
               if (r_vcnt == LAST_VEC) begin
                  r_state <= S_DRAIN;
               end else begin
                  r_vcnt     <= w_vcnt_inc;
                  {r_a, r_b} <= w_vec_next;
               end
            end

            S_DRAIN: begin
               r_err_cnt <= w_err_next;
               r_state   <= S_DONE;
               r_busy    <= 1'b0;
               r_done    <= 1'b1;
               r_pass    <= (w_err_next == '0);
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign io_dut.a  = r_a;
   assign io_dut.b  = r_b;
   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_pass    = r_pass;
   assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_and2_latch_tester.sv
// Bench for and2_latch_tester: a behavioural AND2 partner with fault injection, a vector-level
// reference model for the expected error count, and a second narrow-counter instance for saturation.
module tb_and2_latch_tester;

   localparam int N   = 16;
   localparam int EW  = 8;
   localparam int N2  = 5;
   localparam int EW2 = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          start;
   logic          start2;
   logic          busy, done, pass;
   logic [EW-1:0] err;
   logic          busy2, done2, pass2;
   logic [EW2-1:0] err2;

   and2_latch_tester_if bus ();
   and2_latch_tester_if bus2 ();

   // Fault modes for the main partner: c 0=good 1=stuck0 2=invert 3=per-cycle flip; d 0=good 1=stuck1 3=flip
   int   c_mode;
   int   d_mode;
   logic cflip;
   logic dflip;
   logic gold_d;
   logic gold_d2;
   logic tb_c;
   logic tb_d;

   always @(posedge clk) begin
      gold_d  <= bus.a & bus.b;
      gold_d2 <= bus2.a & bus2.b;
   end

   always_comb begin
      tb_c = bus.a & bus.b;
      case (c_mode)
         1:       tb_c = 1'b0;
         2:       tb_c = ~(bus.a & bus.b);
         3:       tb_c = (bus.a & bus.b) ^ cflip;
         default: tb_c = bus.a & bus.b;
      endcase
      tb_d = gold_d;
      case (d_mode)
         1:       tb_d = 1'b1;
         3:       tb_d = gold_d ^ dflip;
         default: tb_d = gold_d;
      endcase
   end

   assign bus.c  = tb_c;
   assign bus.d  = tb_d;
   assign bus2.c = ~(bus2.a & bus2.b);
   assign bus2.d = gold_d2;

   and2_latch_tester #(.NUM_VECTORS(N), .ERR_W(EW)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_start   (start),
      .io_dut    (bus),
      .o_busy    (busy),
      .o_done    (done),
      .o_pass    (pass),
      .o_err_cnt (err)
   );

   and2_latch_tester #(.NUM_VECTORS(N2), .ERR_W(EW2)) u_sat (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_start   (start2),
      .io_dut    (bus2),
      .o_busy    (busy2),
      .o_done    (done2),
      .o_pass    (pass2),
      .o_err_cnt (err2)
   );

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {a,b} of vector v, derived straight from the pattern definition
   function automatic logic [1:0] model_vec(input int v);
      int l;
`ifdef AND2_LATCH_TESTER_LFSR_EN
      l = 8'hA5;
      for (int i = 0; i < v; i++)
         l = ((l << 1) | (((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1)) & 255;
      return {l[0], l[1]};
`else
      l = v % 4;
      return {l[1], l[0]};
`endif
   endfunction

   // Expected error count: one c-check and one d-check per vector, clamped at the counter maximum
   function automatic int model_err(input int cm, input int dm, input logic [15:0] cmask,
                                    input logic [15:0] dmask, input int n, input int ew);
      int   e;
      logic p, co, dobs;
      logic [1:0] v2;
      e = 0;
      for (int v = 0; v < n; v++) begin
         v2 = model_vec(v);
         p  = v2[1] & v2[0];
         co = (cm == 1) ? 1'b0 : (cm == 2) ? ~p : (cm == 3) ? (p ^ cmask[v]) : p;
         dobs = (dm == 1) ? 1'b1 : (dm == 3) ? (p ^ dmask[v]) : p;
         if (co != p) e++;
         if (dobs != p) e++;
      end
      if (e > (1 << ew) - 1) e = (1 << ew) - 1;
      return e;
   endfunction

   task automatic run(input string tag, input int cm, input int dm,
                      input logic [15:0] cmask, input logic [15:0] dmask);
      int exp_e;
      exp_e  = model_err(cm, dm, cmask, dmask, N, EW);
      c_mode = cm;
      d_mode = dm;
      cflip  = 1'b0;
      dflip  = 1'b0;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      chk({tag, "_busy_at_start"}, 32'(busy), 32'd1);
      chk({tag, "_err_cleared"}, 32'(err), 32'd0);
      for (int j = 1; j <= N + 1; j++) begin
         chk($sformatf("%s_ab_cyc%0d", tag, j - 1), 32'({bus.a, bus.b}),
             32'(model_vec((j - 1 < N - 1) ? j - 1 : N - 1)));
         cflip = (j <= N) ? cmask[j-1] : 1'b0;
         dflip = (j >= 2) ? dmask[j-2] : 1'b0;
         tick();
         if (j <= N) chk($sformatf("%s_busy_cyc%0d", tag, j), 32'({busy, done}), 32'b10);
      end
      cflip = 1'b0;
      dflip = 1'b0;
      $display("run %s: err_cnt=%0d pass=%0b done=%0b (model err=%0d)", tag, err, pass, done, exp_e);
      chk({tag, "_done"}, 32'({busy, done}), 32'b01);
      chk({tag, "_err"}, 32'(err), 32'(exp_e));
      chk({tag, "_pass"}, 32'(pass), 32'(exp_e == 0));
   endtask

   initial begin
      logic [15:0] rm_c, rm_d;
      rst_n  = 1'b0;
      start  = 1'b0;
      start2 = 1'b0;
      c_mode = 0;
      d_mode = 0;
      cflip  = 1'b0;
      dflip  = 1'b0;
      tick();
      tick();
      chk("reset_outputs", 32'({bus.a, bus.b, busy, done, pass}), 32'd0);
      chk("reset_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_no_start", 32'({busy, done}), 32'd0);

      run("golden", 0, 0, 16'h0, 16'h0);
      run("c_stuck0", 1, 0, 16'h0, 16'h0);

      repeat (3) tick();
      chk("done_hold_err", 32'(err), 32'(model_err(1, 0, 16'h0, 16'h0, N, EW)));
      chk("done_hold_flags", 32'({done, pass}), 32'b10);

      run("restart_golden", 0, 0, 16'h0, 16'h0);
      run("d_stuck1", 0, 1, 16'h0, 16'h0);

      for (int r = 0; r < 4; r++) begin
         rm_c = 16'($urandom);
         rm_d = 16'($urandom);
         run($sformatf("rnd%0d", r), 3, 3, rm_c, rm_d);
      end

      // Reset in the middle of a failing run must clear everything at once
      c_mode = 1;
      d_mode = 0;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      chk("midrun_reset_outputs", 32'({bus.a, bus.b, busy, done, pass}), 32'd0);
      chk("midrun_reset_err", 32'(err), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      run("post_reset_golden", 0, 0, 16'h0, 16'h0);

      // Narrow counter with inverted c: errors clamp at 3 and never wrap
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int j = 1; j <= N2 + 1; j++) begin
         tick();
         chk($sformatf("sat_err_cyc%0d", j), 32'(err2), 32'((j < N2 ? j : N2) > 3 ? 3 : (j < N2 ? j : N2)));
      end
      $display("run saturate: err_cnt=%0d pass=%0b done=%0b", err2, pass2, done2);
      chk("sat_done", 32'({busy2, done2, pass2}), 32'b010);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
